// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs in, pipeline-register controls and counters out.
// The master side is the pipeline datapath; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_write_reg;
    logic             mem_branch;
    logic             mem_zero;
    logic             mem_jump;
    logic             mem_memread;
    logic             mem_memwrite;
    logic             dmem_ready;
    logic             pc_write;
    logic             pc_redirect;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             pipe_hold;
    logic             memwb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_write_reg,
               mem_branch, mem_zero, mem_jump, mem_memread, mem_memwrite, dmem_ready,
        input  pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush, exmem_flush,
               pipe_hold, memwb_bubble, mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_write_reg,
               mem_branch, mem_zero, mem_jump, mem_memread, mem_memwrite, dmem_ready,
        output pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush, exmem_flush,
               pipe_hold, memwb_bubble, mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage redirects,
// whole-pipe freeze on a busy data memory with a sticky timeout error.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 16
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic mem_busy_s, load_use_s, take_s, freeze_s, resolve_s;
    logic pc_write_s, pc_redirect_s, ifid_write_s, ifid_flush_s, idex_flush_s;
    logic exmem_flush_s, pipe_hold_s, memwb_bubble_s;

    // Hazard detection and next-state; resolve_s marks cycles judged as an unfrozen RUN cycle
    always_comb begin
        mem_busy_s = (hz.mem_memread | hz.mem_memwrite) & ~hz.dmem_ready;
        load_use_s = hz.ex_memread & (hz.ex_write_reg != 5'd0) &
                     ((hz.ex_write_reg == hz.id_rs) | (hz.id_uses_rt & (hz.ex_write_reg == hz.id_rt)));
        take_s     = (hz.mem_branch & hz.mem_zero) | hz.mem_jump;
        state_d    = state_q;
        wait_d     = wait_q;
        freeze_s   = 1'b0;
        resolve_s  = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_busy_s) begin
                    freeze_s = 1'b1;
                    state_d  = MEM_WAIT;
                    wait_d   = WC_W'(1);
                end else begin
                    resolve_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!hz.dmem_ready) begin
                    freeze_s = 1'b1;
                    wait_d   = wait_q + WC_W'(1);
                    if (wait_q == WC_LAST) begin
                        state_d = ERR;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else begin
                    resolve_s = 1'b1;
                    state_d   = RUN;
                    wait_d    = '0;
                end
            end
            ERR: begin
                freeze_s = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Pipeline-register controls; reset forces every stage to a bubble
    always_comb begin
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        pc_redirect_s  = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_flush_s   = 1'b0;
        exmem_flush_s  = 1'b0;
        pipe_hold_s    = 1'b0;
        memwb_bubble_s = 1'b0;
        if (reset) begin
            pc_write_s     = 1'b0;
            ifid_write_s   = 1'b0;
            ifid_flush_s   = 1'b1;
            idex_flush_s   = 1'b1;
            exmem_flush_s  = 1'b1;
            memwb_bubble_s = 1'b1;
        end else if (freeze_s) begin
            pc_write_s     = 1'b0;
            ifid_write_s   = 1'b0;
            pipe_hold_s    = 1'b1;
            memwb_bubble_s = 1'b1;
        end else if (resolve_s && take_s) begin
            // Redirect wins over load-use: the stalled ID instruction is squashed anyway
            pc_redirect_s = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
        end else if (resolve_s && load_use_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
        end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
        end
    end

    // State, wait counter and saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!pc_write_s && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (pc_redirect_s && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_write     = pc_write_s;
    assign hz.pc_redirect  = pc_redirect_s;
    assign hz.ifid_write   = ifid_write_s;
    assign hz.ifid_flush   = ifid_flush_s;
    assign hz.idex_flush   = idex_flush_s;
    assign hz.exmem_flush  = exmem_flush_s;
    assign hz.pipe_hold    = pipe_hold_s;
    assign hz.memwb_bubble = memwb_bubble_s;
    assign hz.mem_timeout  = (state_q == ERR) & ~reset;
    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, a saturation sequence,
// and randomized stimulus against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int TMO   = 4;
    localparam int CW    = 8;
    localparam int MAXC  = (1 << CW) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       ex_mr;
        logic [4:0] ex_wr;
        logic       br;
        logic       zero;
        logic       jmp;
        logic       mmr;
        logic       mmw;
        logic       rdy;
    } in_t;

    // pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, memwb_bubble, pc_redirect, mem_timeout
    typedef logic [8:0] ctl_t;

    typedef struct {
        in_t  in;
        ctl_t ctl;
        int   stall;
        int   flush;
    } row_t;

    localparam ctl_t DEF  = 9'b110000000;
    localparam ctl_t RSTV = 9'b001110100;
    localparam ctl_t BUBL = 9'b000100000;
    localparam ctl_t REDR = 9'b111110010;
    localparam ctl_t FRZ  = 9'b000001100;
    localparam ctl_t ERRV = 9'b000001101;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state: in a memory wait, in error, consecutive freeze length, visible counters
    bit m_waiting, m_err;
    int m_len, m_stall, m_flush;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hif ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic ur, logic exmr,
                               logic [4:0] exwr, logic br, logic z, logic j, logic mr, logic mw,
                               logic rdy);
        in_t v;
        v = '{rst, rs, rt, ur, exmr, exwr, br, z, j, mr, mw, rdy};
        return v;
    endfunction

    function automatic ctl_t model_ctl(in_t v);
        bit busy, lu, take, frozen;
        busy   = (v.mmr | v.mmw) & ~v.rdy;
        lu     = v.ex_mr && v.ex_wr != 0 && (v.ex_wr == v.rs || (v.uses_rt && v.ex_wr == v.rt));
        take   = (v.br & v.zero) | v.jmp;
        frozen = m_waiting ? !v.rdy : busy;
        if (v.rst)      return RSTV;
        else if (m_err) return ERRV;
        else if (frozen) return FRZ;
        else if (take)  return REDR;
        else if (lu)    return BUBL;
        else            return DEF;
    endfunction

    task automatic model_update(in_t v, ctl_t c);
        if (v.rst) begin
            m_waiting = 0; m_err = 0; m_len = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!c[8]) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
            if (c[1])  m_flush = (m_flush < MAXC) ? m_flush + 1 : MAXC;
            if (!m_err) begin
                if (c == FRZ) begin
                    m_len++;
                    m_waiting = 1;
                    if (m_len >= TMO) m_err = 1;
                end else begin
                    m_waiting = 0;
                    m_len = 0;
                end
            end
        end
    endtask

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // One clock: drive inputs, sample outputs mid-cycle, then advance the model at the edge
    task automatic run_cycle(input in_t v, output ctl_t act, output int st, output int fl,
                             output ctl_t exp, output int est, output int efl);
        reset            = v.rst;
        hif.id_rs        = v.rs;
        hif.id_rt        = v.rt;
        hif.id_uses_rt   = v.uses_rt;
        hif.ex_memread   = v.ex_mr;
        hif.ex_write_reg = v.ex_wr;
        hif.mem_branch   = v.br;
        hif.mem_zero     = v.zero;
        hif.mem_jump     = v.jmp;
        hif.mem_memread  = v.mmr;
        hif.mem_memwrite = v.mmw;
        hif.dmem_ready   = v.rdy;
        exp = model_ctl(v);
        est = m_stall;
        efl = m_flush;
        @(negedge clk);
        act = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_flush, hif.exmem_flush,
               hif.pipe_hold, hif.memwb_bubble, hif.pc_redirect, hif.mem_timeout};
        st = int'(hif.stall_cycles);
        fl = int'(hif.flush_events);
        @(posedge clk);
        model_update(v, exp);
        #1;
    endtask

    row_t tbl[24];

    initial begin
        ctl_t act, exp;
        int st, fl, est, efl;
        in_t idle, v;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RSTV, 0, 0};
        tbl[1]  = '{idle,                                    DEF,  0, 0};
        tbl[2]  = '{mk(0, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1), BUBL, 0, 0};
        tbl[3]  = '{idle,                                    DEF,  1, 0};
        tbl[4]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), DEF,  1, 0};
        tbl[5]  = '{mk(0, 3, 7, 0, 1, 7, 0, 0, 0, 0, 0, 1), DEF,  1, 0};
        tbl[6]  = '{mk(0, 3, 7, 1, 1, 7, 0, 0, 0, 0, 0, 1), BUBL, 1, 0};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1), REDR, 2, 0};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), DEF,  2, 1};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), REDR, 2, 1};
        tbl[10] = '{mk(0, 5, 0, 0, 1, 5, 0, 0, 1, 0, 0, 1), REDR, 2, 2};
        tbl[11] = '{mk(0, 5, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0), FRZ,  2, 3};
        tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), FRZ,  3, 3};
        tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), FRZ,  4, 3};
        tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), DEF,  5, 3};
        tbl[15] = '{idle,                                    DEF,  5, 3};
        tbl[16] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), FRZ,  5, 3};
        tbl[17] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), FRZ,  6, 3};
        tbl[18] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), FRZ,  7, 3};
        tbl[19] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), FRZ,  8, 3};
        tbl[20] = '{idle,                                    ERRV, 9, 3};
        tbl[21] = '{idle,                                    ERRV, 10, 3};
        tbl[22] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), RSTV, 11, 3};
        tbl[23] = '{idle,                                    DEF,  0, 0};

        m_waiting = 0; m_err = 0; m_len = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        // First reset cycle: counters are still unknown, so nothing is checked here
        run_cycle(tbl[0].in, act, st, fl, exp, est, efl);

        for (int i = 0; i < 24; i++) begin
            run_cycle(tbl[i].in, act, st, fl, exp, est, efl);
            chk("vec_ctl", i, 32'(act), 32'(tbl[i].ctl));
            chk("vec_stall", i, st, tbl[i].stall);
            chk("vec_flush", i, fl, tbl[i].flush);
        end

        // Hung memory long enough to saturate the stall counter
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < MAXC + 10; i++) begin
            run_cycle(v, act, st, fl, exp, est, efl);
        end
        run_cycle(v, act, st, fl, exp, est, efl);
        chk("sat_stall", 0, st, MAXC);
        chk("sat_ctl", 0, 32'(act), 32'(ERRV));
        run_cycle(tbl[0].in, act, st, fl, exp, est, efl);
        run_cycle(idle, act, st, fl, exp, est, efl);
        chk("sat_clear", 0, st, 0);

        for (int i = 0; i < 3000; i++) begin
            v.rst     = ($urandom_range(0, 49) == 0);
            v.rs      = 5'($urandom_range(0, 3));
            v.rt      = 5'($urandom_range(0, 3));
            v.uses_rt = 1'($urandom_range(0, 1));
            v.ex_mr   = 1'($urandom_range(0, 1));
            v.ex_wr   = 5'($urandom_range(0, 3));
            v.br      = ($urandom_range(0, 3) == 0);
            v.zero    = 1'($urandom_range(0, 1));
            v.jmp     = ($urandom_range(0, 7) == 0);
            v.mmr     = ($urandom_range(0, 3) == 0);
            v.mmw     = ($urandom_range(0, 7) == 0);
            v.rdy     = 1'($urandom_range(0, 1));
            run_cycle(v, act, st, fl, exp, est, efl);
            chk("rnd_ctl", i, 32'(act), 32'(exp));
            chk("rnd_cnt", i, {st[15:0], fl[15:0]}, {est[15:0], efl[15:0]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
